// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - Parallel-in / serial-out handshake bundle for uart_tx
//
// Purpose: groups the byte request, frame settings and serial/busy status
// of the UART transmitter.
// Ports (signals):
//   P_DATA     [DATA_WIDTH] byte to transmit, sampled on acceptance
//   DATA_VALID              transmit request
//   PAR_EN                  1 = parity bit present
//   PAR_TYP                 0 = even, 1 = odd parity
//   Prescale   [6]          clk cycles per serial bit (0 behaves as 1)
//   TX_OUT                  serial line, idle high
//   Busy                    frame in progress
// Modports: master drives the request side, slave is the transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop
//
// Purpose: serialises one byte per accepted request. Each bit is held for
// the latched Prescale number of clk cycles.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  uart_tx_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale
//        in; TX_OUT, Busy out, both registered)
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            prescale_q;
  logic [5:0]            cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tx_out_q;
  logic                  busy_q;
  logic                  bit_done;

  // Last clk cycle of the current serial bit.
  assign bit_done = (cnt == prescale_q - 6'd1);

  assign bus.TX_OUT = tx_out_q;
  assign bus.Busy   = busy_q;

  // TX_OUT is loaded with the next bit on the edge that ends the current
  // one, so the line value always lines up with the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= 6'd0;
      cnt        <= 6'd0;
      bit_idx    <= '0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.DATA_VALID) begin
            data_q     <= bus.P_DATA;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            prescale_q <= (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
            cnt        <= 6'd0;
            bit_idx    <= '0;
            tx_out_q   <= 1'b0;
            busy_q     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt      <= 6'd0;
            tx_out_q <= data_q[0];
            state    <= DATA;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= 6'd0;
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              if (par_en_q) begin
                tx_out_q <= (^data_q) ^ par_typ_q;
                state    <= PARITY;
              end else begin
                tx_out_q <= 1'b1;
                state    <= STOP;
              end
            end else begin
              bit_idx  <= bit_idx + IDX_ONE;
              tx_out_q <= data_q[bit_idx + IDX_ONE];
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt      <= 6'd0;
            tx_out_q <= 1'b1;
            state    <= STOP;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt      <= 6'd0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - Self-checking bench for uart_tx
module tb_uart_tx;
  logic clk;
  logic rst;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
    int         len;
    logic       par;
  } vec_t;

  vec_t vecs[10];

  int checks   = 0;
  int failures = 0;

  logic tx_s   [0:1023];
  logic busy_s [0:1023];
  logic exp_tx   [$];
  logic exp_busy [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic sample_one(input int i);
    @(posedge clk);
    #1;
    tx_s[i]   = bus.TX_OUT;
    busy_s[i] = bus.Busy;
  endtask

  // Reference waveform: a frame is the list of line levels, each repeated
  // for the effective bit period; Busy covers the whole frame.
  task automatic model_clear();
    exp_tx.delete();
    exp_busy.delete();
  endtask

  task automatic model_frame(input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps);
    logic bits [$];
    int   eff;
    int   ones;
    eff  = (ps == 0) ? 1 : int'(ps);
    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      bits.push_back(d[k]);
      if (d[k]) ones++;
    end
    if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < eff; c++) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
      end
  endtask

  task automatic model_idle(input int n);
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic cmp_wave(input string name, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= exp_tx.size()) errs++;
      else if (tx_s[i] !== exp_tx[i] || busy_s[i] !== exp_busy[i]) errs++;
    end
    check({name, "_wave_errs"}, errs, 0);
  endtask

  // Mid-bit sampling receiver, as the far end of the line would decode it.
  task automatic rx_decode(input string name, input logic [7:0] d, input logic pe,
                           input logic pt, input logic [5:0] ps);
    int eff;
    int nb;
    logic [7:0] rx;
    logic ok;
    eff = (ps == 0) ? 1 : int'(ps);
    nb  = pe ? 11 : 10;
    ok  = (tx_s[eff / 2] == 1'b0) && (tx_s[(nb - 1) * eff + eff / 2] == 1'b1);
    for (int k = 0; k < 8; k++) rx[k] = tx_s[(k + 1) * eff + eff / 2];
    if (pe && ((^rx ^ pt) != tx_s[9 * eff + eff / 2])) ok = 1'b0;
    check({name, "_rx_data"}, int'(rx), int'(d));
    check({name, "_rx_frame_ok"}, int'(ok), 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int n;
    int busy_cnt;
    string name;
    v = vecs[idx];
    name = $sformatf("vec%0d", idx);
    bus.P_DATA     = v.d;
    bus.PAR_EN     = v.pe;
    bus.PAR_TYP    = v.pt;
    bus.Prescale   = v.ps;
    bus.DATA_VALID = 1'b1;
    sample_one(0);
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = 8'($urandom);
    bus.PAR_EN     = 1'($urandom);
    bus.PAR_TYP    = 1'($urandom);
    bus.Prescale   = 6'($urandom);
    n = v.len + 2;
    for (int i = 1; i < n; i++) sample_one(i);
    model_clear();
    model_frame(v.d, v.pe, v.pt, v.ps);
    model_idle(2);
    cmp_wave(name, n);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) if (busy_s[i]) busy_cnt++;
    check({name, "_busy_cycles"}, busy_cnt, v.len);
    if (v.pe) begin
      int eff;
      eff = (v.ps == 0) ? 1 : int'(v.ps);
      check({name, "_parity"}, int'(tx_s[9 * eff]), int'(v.par));
    end
    rx_decode(name, v.d, v.pe, v.pt, v.ps);
  endtask

  initial begin
    int errs;
    rst            = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd8;

    vecs[0] = '{8'h45, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 6'd16, 176, 1'b0};
    vecs[2] = '{8'hA8, 1'b1, 1'b1, 6'd32, 352, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 6'd0,  11,  1'b1};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 6'd1,  10,  1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 6'd63, 693, 1'b1};
    for (int i = 6; i < 10; i++) begin
      vecs[i].d   = 8'($urandom);
      vecs[i].pe  = 1'($urandom);
      vecs[i].pt  = 1'($urandom);
      vecs[i].ps  = 6'($urandom_range(0, 12));
      vecs[i].len = (vecs[i].pe ? 11 : 10) * ((vecs[i].ps == 0) ? 1 : int'(vecs[i].ps));
      vecs[i].par = (^vecs[i].d) ^ vecs[i].pt;
    end

    // Reset held with a pending request: nothing may start.
    bus.DATA_VALID = 1'b1;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      sample_one(i);
      if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0) errs++;
    end
    check("reset_hold_idle_errs", errs, 0);
    bus.DATA_VALID = 1'b0;
    rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      sample_one(i);
      if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0) errs++;
    end
    check("post_reset_idle_errs", errs, 0);

    // Abort during data bit 3 of 0x45 (samples 32..39 with Prescale 8).
    bus.P_DATA = 8'h45; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
    bus.DATA_VALID = 1'b1;
    sample_one(0);
    bus.DATA_VALID = 1'b0;
    for (int i = 1; i <= 34; i++) sample_one(i);
    check("abort_pre_tx_bit3", int'(tx_s[34]), 0);
    rst = 1'b0;
    #1;
    check("abort_tx_same_cycle", int'(bus.TX_OUT), 1);
    check("abort_busy_same_cycle", int'(bus.Busy), 0);
    #2;
    rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      sample_one(i);
      if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0) errs++;
    end
    check("abort_residual_errs", errs, 0);

    // Request during a frame is ignored; held request starts after one idle cycle.
    bus.P_DATA = 8'h45; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
    bus.DATA_VALID = 1'b1;
    sample_one(0);
    bus.DATA_VALID = 1'b0;
    for (int i = 1; i < 163; i++) begin
      sample_one(i);
      if (i == 20) begin
        bus.P_DATA     = 8'h3C;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 81) bus.DATA_VALID = 1'b0;
    end
    model_clear();
    model_frame(8'h45, 1'b0, 1'b0, 6'd8);
    model_idle(1);
    model_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    model_idle(2);
    cmp_wave("back_to_back", 163);
    check("b2b_idle_gap_tx", int'(tx_s[80]), 1);
    check("b2b_second_start", int'(tx_s[81]), 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of payload bits per frame; all values below assume 8.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: P_DATA  input  8  parallel byte to transmit, sampled only on acceptance.
REQ-005 Port: DATA_VALID  input  1  request to transmit P_DATA.
REQ-006 Port: PAR_EN  input  1  1 = parity bit inserted after data, 0 = no parity bit.
REQ-007 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port: Prescale  input  6  clk cycles per serial bit; 0 treated as 1.
REQ-009 Port: TX_OUT  output  1  serial line, idle high, registered.
REQ-010 Port: Busy  output  1  high while a frame is in progress, registered.

Function
REQ-011 Frame format SHALL be: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE->START on accept.
- START->DATA after Prescale cycles.
- DATA->PARITY (PAR_EN=1) or DATA->STOP (PAR_EN=0) after bit 7's Prescale cycles.
- PARITY->STOP after Prescale cycles.
- STOP->IDLE after Prescale cycles.
REQ-013 Acceptance SHALL occur on a rising edge where state=IDLE and DATA_VALID=1. On that edge: P_DATA, PAR_EN, PAR_TYP and Prescale are latched, TX_OUT<=0 and Busy<=1.
REQ-014 DATA_VALID asserted while Busy=1 SHALL be ignored; no queuing, and latched data and settings are unaffected.
REQ-015 Input changes to P_DATA/PAR_EN/PAR_TYP/Prescale after acceptance SHALL NOT affect the frame in progress.
REQ-016 Each bit SHALL drive TX_OUT for exactly latched-Prescale clk cycles. This uses a 6-bit cycle counter (0..Prescale-1) and a 3-bit bit index (0..7) that wraps only on the DATA->next-state transition.
REQ-017 Parity bit SHALL be XOR of the 8 latched data bits when PAR_TYP=0 (even), and its inverse when PAR_TYP=1 (odd).
REQ-018 Busy SHALL fall on the edge leaving STOP, and TX_OUT SHALL remain 1.
REQ-019 Back-to-back transfers: at least one IDLE cycle (TX_OUT=1) SHALL separate frames. A DATA_VALID held high SHALL be accepted on the first IDLE cycle's edge.
REQ-020 Frame duration from acceptance edge to Busy fall SHALL be 10*Prescale cycles (PAR_EN=0) or 11*Prescale cycles (PAR_EN=1).
REQ-021 A frame SHALL be decodable by the team's UART receiver when both are configured with identical Prescale, PAR_EN and PAR_TYP.

Reset
REQ-022 rst=0 SHALL immediately, without a clock, force state=IDLE, TX_OUT=1, Busy=0, and clear counters and the data register to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame. After release, no residual bits are sent, and the next DATA_VALID starts a fresh frame.
REQ-024 DATA_VALID SHALL NOT be accepted while rst=0.

Verification
REQ-025 Test: Reset, then idle 5 cycles -> TX_OUT=1, Busy=0 throughout.
REQ-026 Test: P_DATA=0x45, PAR_EN=0, Prescale=8, 1-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,0,1,0,1, each bit held 8 cycles; Busy high 80 cycles.
REQ-027 Test: P_DATA=0xFF, PAR_EN=1, PAR_TYP=0, Prescale=16 -> parity bit 0, 11 bits of 16 cycles, Busy high 176 cycles.
REQ-028 Test: P_DATA=0xA8, PAR_EN=1, PAR_TYP=1, Prescale=32 -> parity bit 0 after data 0,0,0,1,0,1,0,1; Busy high 352 cycles. Looped into the UART receiver with the same settings, the receiver reports P_DATA=0xA8 with data_valid=1.
REQ-029 Test: DATA_VALID=1 with P_DATA=0x3C during a 0x45 frame -> ignored; 0x45 frame unchanged. DATA_VALID held high -> second frame 0x3C starts after exactly one IDLE cycle.
REQ-030 Test: rst=0 during data bit 3 of 0x45 -> same-cycle TX_OUT=1, Busy=0. After release with no DATA_VALID, TX_OUT stays 1 for 100 cycles.
